// File: rtl/mdu_core.sv
// mdu_core: EX-stage multiply/divide unit owning the architectural HI/LO pair.
//   DIV/DIVU run a 32-step restoring divider; MUL/MULT/MULTU produce a 64-bit
//   product over MUL_CYCLES busy cycles; MFHI/MFLO/MTHI/MTLO are served in IDLE.
// Ports:
//   clk, rst_n       core clock, asynchronous active-low reset
//   mdu_valid_i      EX holds a live instruction
//   mdu_op_i         0 none,1 DIV,2 DIVU,3 MUL,4 MULT,5 MULTU,6 MFHI,7 MFLO,8 MTHI,9 MTLO
//   mdu_a_i/mdu_b_i  rs/rt operands
//   flush_i          EX instruction killed
//   mdu_result_o     rd value for MFHI/MFLO/MUL, 0 otherwise
//   mdu_stall_o      hold IF/ID/EX this cycle
//   hi_o/lo_o        current HI/LO
module mdu_core #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdu_valid_i,
  input  logic [3:0]  mdu_op_i,
  input  logic [31:0] mdu_a_i,
  input  logic [31:0] mdu_b_i,
  input  logic        flush_i,
  output logic [31:0] mdu_result_o,
  output logic        mdu_stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_MULT_BUSY = 2'd1;
  localparam logic [1:0] ST_DIV_BUSY  = 2'd2;
  localparam logic [1:0] ST_MUL_WB    = 2'd3;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_MULT  = 4'd4;
  localparam logic [3:0] OP_MULTU = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [63:0] product;
  logic        mul_rd;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [31:0] a_orig;
  logic        neg_q;
  logic        neg_r;
  logic        div_zero;

  logic [3:0]  op_eff;
  logic        req;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [63:0] prod_signed;
  logic [63:0] prod_unsigned;
  logic [32:0] rem_shift;
  logic [32:0] rem_sub;
  logic        sub_ok;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] lo_fin;
  logic [31:0] hi_fin;
  logic        unused_rem_msb;

  // Fold the reserved opcodes 10-15 onto "no operation".
  always_comb begin
    if (mdu_op_i <= OP_MTLO) begin
      op_eff = mdu_op_i;
    end else begin
      op_eff = OP_NONE;
    end
  end

  assign req = mdu_valid_i && !flush_i && (op_eff != OP_NONE);

  // Magnitudes for signed division; DIVU passes operands through untouched.
  always_comb begin
    a_neg = (op_eff == OP_DIV) && mdu_a_i[31];
    b_neg = (op_eff == OP_DIV) && mdu_b_i[31];
    if (a_neg) begin
      a_abs = 32'd0 - mdu_a_i;
    end else begin
      a_abs = mdu_a_i;
    end
    if (b_neg) begin
      b_abs = 32'd0 - mdu_b_i;
    end else begin
      b_abs = mdu_b_i;
    end
  end

  assign prod_signed   = $signed({{32{mdu_a_i[31]}}, mdu_a_i}) * $signed({{32{mdu_b_i[31]}}, mdu_b_i});
  assign prod_unsigned = {32'd0, mdu_a_i} * {32'd0, mdu_b_i};

  // One restoring step: the dividend shifts out of quo's MSB into the remainder,
  // and the freed LSB of quo collects the new quotient bit.
  assign rem_shift      = {rem, quo[31]};
  assign rem_sub        = rem_shift - {1'b0, dvs};
  assign sub_ok         = (rem_shift >= {1'b0, dvs});
  assign quo_next       = {quo[30:0], sub_ok};
  // A successful trial subtract always leaves a value below the divisor.
  assign unused_rem_msb = rem_sub[32];

  // Select the remainder after the trial subtract.
  always_comb begin
    if (sub_ok) begin
      rem_next = rem_sub[31:0];
    end else begin
      rem_next = rem_shift[31:0];
    end
  end

  // Sign fixup of the final step, with divide-by-zero overriding the datapath.
  always_comb begin
    if (div_zero) begin
      lo_fin = 32'hFFFF_FFFF;
      hi_fin = a_orig;
    end else begin
      if (neg_q) begin
        lo_fin = 32'd0 - quo_next;
      end else begin
        lo_fin = quo_next;
      end
      if (neg_r) begin
        hi_fin = 32'd0 - rem_next;
      end else begin
        hi_fin = rem_next;
      end
    end
  end

  // Stall and rd result; MUL_WB is the held MUL leaving EX, so it never stalls.
  always_comb begin
    mdu_stall_o  = 1'b0;
    mdu_result_o = 32'd0;
    if (state == ST_IDLE) begin
      mdu_stall_o = req && (op_eff == OP_MUL);
      if (req && (op_eff == OP_MFHI)) begin
        mdu_result_o = hi;
      end else if (req && (op_eff == OP_MFLO)) begin
        mdu_result_o = lo;
      end else begin
        mdu_result_o = 32'd0;
      end
    end else if (state == ST_MUL_WB) begin
      mdu_stall_o = 1'b0;
      if (!flush_i) begin
        mdu_result_o = product[31:0];
      end else begin
        mdu_result_o = 32'd0;
      end
    end else begin
      mdu_stall_o  = req;
      mdu_result_o = 32'd0;
    end
  end

  assign hi_o = hi;
  assign lo_o = lo;

  // Control FSM, HI/LO and multiply/divide datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 8'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      product  <= 64'd0;
      mul_rd   <= 1'b0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      dvs      <= 32'd0;
      a_orig   <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            case (op_eff)
              OP_DIV, OP_DIVU: begin
                rem      <= 32'd0;
                quo      <= a_abs;
                dvs      <= b_abs;
                a_orig   <= mdu_a_i;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= (mdu_b_i == 32'd0);
                cnt      <= DIV_LOAD;
                state    <= ST_DIV_BUSY;
              end
              OP_MUL, OP_MULT: begin
                product <= prod_signed;
                mul_rd  <= (op_eff == OP_MUL);
                cnt     <= MUL_LOAD;
                state   <= ST_MULT_BUSY;
              end
              OP_MULTU: begin
                product <= prod_unsigned;
                mul_rd  <= 1'b0;
                cnt     <= MUL_LOAD;
                state   <= ST_MULT_BUSY;
              end
              OP_MTHI: hi <= mdu_a_i;
              OP_MTLO: lo <= mdu_a_i;
              default: state <= ST_IDLE;
            endcase
          end
        end
        ST_MULT_BUSY: begin
          // Only a MUL still waiting in EX can be killed; MULT/MULTU already retired.
          if (mul_rd && flush_i) begin
            mul_rd <= 1'b0;
            state  <= ST_IDLE;
          end else if (cnt == 8'd0) begin
            if (mul_rd) begin
              state <= ST_MUL_WB;
            end else begin
              hi    <= product[63:32];
              lo    <= product[31:0];
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_MUL_WB: begin
          mul_rd <= 1'b0;
          state  <= ST_IDLE;
        end
        ST_DIV_BUSY: begin
          rem <= rem_next;
          quo <= quo_next;
          if (cnt == 8'd0) begin
            hi    <= hi_fin;
            lo    <= lo_fin;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_core.sv
// tb_mdu_core: directed stimulus for mdu_core with a transaction-level model
// (unit busy-cycle budget plus arithmetic results) checked every negedge, and
// hand-computed literal checks on the architectural effects.
module tb_mdu_core;

  localparam int MUL_CYCLES = 2;
  localparam int DIV_CYCLES = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdu_valid_i = 1'b0;
  logic [3:0]  mdu_op_i = 4'd0;
  logic [31:0] mdu_a_i = 32'd0;
  logic [31:0] mdu_b_i = 32'd0;
  logic        flush_i = 1'b0;
  logic [31:0] mdu_result_o;
  logic        mdu_stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: architectural HI/LO, cycles the unit stays occupied, pending results.
  logic [31:0] m_hi, m_lo, m_phi, m_plo, m_mulres;
  int          m_busy;
  logic        m_pw, m_mulp, m_wb;

  mdu_core #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .mdu_valid_i(mdu_valid_i), .mdu_op_i(mdu_op_i),
    .mdu_a_i(mdu_a_i), .mdu_b_i(mdu_b_i), .flush_i(flush_i),
    .mdu_result_o(mdu_result_o), .mdu_stall_o(mdu_stall_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0; m_mulres = 32'd0;
    m_busy = 0; m_pw = 1'b0; m_mulp = 1'b0; m_wb = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_step();
    logic [3:0]  op;
    logic        req;
    longint      sa, sb, q, r;
    logic [63:0] t, u;
    op  = (mdu_op_i <= 4'd9) ? mdu_op_i : 4'd0;
    req = mdu_valid_i && !flush_i && (op != 4'd0);
    if (m_wb) begin
      m_wb = 1'b0;
    end else if (m_busy > 0) begin
      if (m_mulp && flush_i) begin
        m_busy = 0; m_mulp = 1'b0;
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          if (m_pw) begin m_hi = m_phi; m_lo = m_plo; m_pw = 1'b0; end
          if (m_mulp) begin m_wb = 1'b1; m_mulp = 1'b0; end
        end
      end
    end else if (req) begin
      case (op)
        4'd1, 4'd2: begin
          if (mdu_b_i == 32'd0) begin
            m_phi = mdu_a_i; m_plo = 32'hFFFF_FFFF;
          end else begin
            if (op == 4'd1) begin
              sa = longint'($signed(mdu_a_i)); sb = longint'($signed(mdu_b_i));
            end else begin
              sa = {32'd0, mdu_a_i}; sb = {32'd0, mdu_b_i};
            end
            q = sa / sb; r = sa % sb; t = q; u = r;
            m_plo = t[31:0]; m_phi = u[31:0];
          end
          m_pw = 1'b1; m_busy = DIV_CYCLES;
        end
        4'd3: begin m_mulres = mdu_a_i * mdu_b_i; m_mulp = 1'b1; m_busy = MUL_CYCLES; end
        4'd4, 4'd5: begin
          if (op == 4'd4) begin
            sa = longint'($signed(mdu_a_i)); sb = longint'($signed(mdu_b_i));
          end else begin
            sa = {32'd0, mdu_a_i}; sb = {32'd0, mdu_b_i};
          end
          t = sa * sb; m_phi = t[63:32]; m_plo = t[31:0];
          m_pw = 1'b1; m_busy = MUL_CYCLES;
        end
        4'd8: m_hi = mdu_a_i;
        4'd9: m_lo = mdu_a_i;
        default: ;
      endcase
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  initial begin
    logic [3:0]  op;
    logic        req, e_stall;
    logic [31:0] e_res;
    forever begin
      @(negedge clk);
      op  = (mdu_op_i <= 4'd9) ? mdu_op_i : 4'd0;
      req = mdu_valid_i && !flush_i && (op != 4'd0);
      if (m_wb) begin
        e_stall = 1'b0; e_res = flush_i ? 32'd0 : m_mulres;
      end else if (m_busy > 0) begin
        e_stall = req; e_res = 32'd0;
      end else begin
        e_stall = req && (op == 4'd3);
        e_res = (req && op == 4'd6) ? m_hi : (req && op == 4'd7) ? m_lo : 32'd0;
      end
      chk("stall", {31'd0, mdu_stall_o}, {31'd0, e_stall});
      chk("result", mdu_result_o, e_res);
      chk("hi", hi_o, m_hi);
      chk("lo", lo_o, m_lo);
    end
  end

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic fl);
    mdu_valid_i = v; mdu_op_i = op; mdu_a_i = a; mdu_b_i = b; flush_i = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_clear(); else model_step();
    #1;
  endtask

  // Present an op and hold it while stalled; report stall cycles and the
  // result seen in the first non-stalled cycle, then let that edge pass.
  task automatic issue_held(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int stalls, output logic [31:0] res);
    logic done;
    drive(1'b1, op, a, b, 1'b0);
    stalls = 0; res = 32'd0; done = 1'b0;
    for (int k = 0; k < 64; k++) begin
      #2;
      if (!mdu_stall_o) begin
        res = mdu_result_o; done = 1'b1;
        break;
      end
      stalls++;
      tick();
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: op %0d still stalled after 64 cycles", op);
    end
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    int          st;
    logic [31:0] res;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_stall", {31'd0, mdu_stall_o}, 32'd0);
    chk("rst_result", mdu_result_o, 32'd0);

    // DIV -7/2: no stall at issue, results land 33 edges after issue.
    issue_held(4'd1, 32'hFFFF_FFF9, 32'd2, st, res);
    chk("div_issue_stall", st, 32'd0);
    repeat (31) tick();
    chk("div_not_early", lo_o, 32'd0);
    tick();
    chk("div_neg_lo", lo_o, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi_o, 32'hFFFF_FFFF);

    // DIVU 0xFFFFFFFF/0x10.
    issue_held(4'd2, 32'hFFFF_FFFF, 32'h10, st, res);
    repeat (32) tick();
    chk("divu_lo", lo_o, 32'h0FFF_FFFF);
    chk("divu_hi", hi_o, 32'h0000_000F);

    // MULT / MULTU 0x80000000 * 2.
    issue_held(4'd4, 32'h8000_0000, 32'd2, st, res);
    tick();
    chk("mult_not_early", hi_o, 32'h0000_000F);
    tick();
    chk("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", lo_o, 32'd0);
    issue_held(4'd5, 32'h8000_0000, 32'd2, st, res);
    repeat (2) tick();
    chk("multu_hi", hi_o, 32'd1);
    chk("multu_lo", lo_o, 32'd0);

    // MUL 3 * -5: stalls in the issue cycle plus MUL_CYCLES busy cycles.
    issue_held(4'd8, 32'h1234, 32'd0, st, res);
    issue_held(4'd9, 32'h5678, 32'd0, st, res);
    issue_held(4'd3, 32'd3, 32'hFFFF_FFFB, st, res);
    chk("mul_stall_cycles", st, 32'd3);
    chk("mul_result", res, 32'hFFFF_FFF1);
    chk("mul_hi_kept", hi_o, 32'h1234);
    chk("mul_lo_kept", lo_o, 32'h5678);

    // DIV 100/7 followed by MFLO waiting for the whole division.
    issue_held(4'd1, 32'd100, 32'd7, st, res);
    issue_held(4'd7, 32'd0, 32'd0, st, res);
    chk("mflo_wait_cycles", st, 32'd32);
    chk("mflo_quotient", res, 32'h0000_000E);
    repeat (2) tick();
    chk("div100_hi", hi_o, 32'd2);

    // Divide by zero and the most-negative / -1 case.
    issue_held(4'd1, 32'h64, 32'd0, st, res);
    repeat (32) tick();
    chk("divz_hi", hi_o, 32'h64);
    chk("divz_lo", lo_o, 32'hFFFF_FFFF);
    issue_held(4'd1, 32'h8000_0000, 32'hFFFF_FFFF, st, res);
    repeat (32) tick();
    chk("divovf_lo", lo_o, 32'h8000_0000);
    chk("divovf_hi", hi_o, 32'd0);

    // Non-MDU ops pass while busy; a queued MTHI waits for the divider.
    issue_held(4'd2, 32'd1000, 32'd3, st, res);
    drive(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
    tick();
    drive(1'b1, 4'd12, 32'h1, 32'h1, 1'b0);
    #2;
    chk("reserved_op_stall", {31'd0, mdu_stall_o}, 32'd0);
    tick();
    issue_held(4'd8, 32'h99, 32'd0, st, res);
    chk("mthi_wait_cycles", st, 32'd30);
    chk("mthi_after_div_hi", hi_o, 32'h99);
    chk("divu1000_lo", lo_o, 32'h14D);

    // MULT still completes when the following instruction is flushed.
    issue_held(4'd4, 32'd7, 32'hFFFF_FFFD, st, res);
    drive(1'b1, 4'd4, 32'd7, 32'hFFFF_FFFD, 1'b1);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    tick();
    chk("mult_flush_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_flush_lo", lo_o, 32'hFFFF_FFEB);

    // MUL killed while busy: back to IDLE, no result, HI/LO intact.
    issue_held(4'd8, 32'hAA, 32'd0, st, res);
    issue_held(4'd9, 32'hBB, 32'd0, st, res);
    drive(1'b1, 4'd3, 32'd5, 32'd6, 1'b0);
    #2;
    chk("mulk_issue_stall", {31'd0, mdu_stall_o}, 32'd1);
    tick();
    drive(1'b1, 4'd3, 32'd5, 32'd6, 1'b1);
    #2;
    chk("mulk_flush_stall", {31'd0, mdu_stall_o}, 32'd0);
    chk("mulk_flush_result", mdu_result_o, 32'd0);
    tick();
    drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
    #2;
    chk("mulk_mflo_stall", {31'd0, mdu_stall_o}, 32'd0);
    chk("mulk_mflo_result", mdu_result_o, 32'hBB);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    repeat (4) tick();
    chk("mulk_hi", hi_o, 32'hAA);
    chk("mulk_lo", lo_o, 32'hBB);

    // Reset at iteration 10 of a DIV: everything cleared, no late write.
    issue_held(4'd1, 32'd1000, 32'd3, st, res);
    repeat (10) tick();
    rst_n = 1'b0;
    model_clear();
    drive(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
    #2;
    chk("midrst_hi", hi_o, 32'd0);
    chk("midrst_lo", lo_o, 32'd0);
    chk("midrst_stall", {31'd0, mdu_stall_o}, 32'd0);
    chk("midrst_result", mdu_result_o, 32'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    repeat (40) tick();
    chk("midrst_no_late_hi", hi_o, 32'd0);
    chk("midrst_no_late_lo", lo_o, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
